// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the instruction/data memory bus arbiter.
package mem_arbiter_pkg;

  // Bus widths reused from the core's instruction bus definitions.
  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned InstBus     = 32;

  // Arbiter FSM encoding.
  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StIfXfer = 2'b01,
    StDmXfer = 2'b10
  } arb_state_e;

  localparam logic Enable    = 1'b1;
  localparam logic Disable   = 1'b0;
  localparam logic RstActive = 1'b0;

  // Fetches always read a full word.
  localparam logic [3:0] SelWord = 4'b1111;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one memory bus between instruction fetch and the load/store unit.
// Data side has priority; a starvation counter forces a fetch grant after
// DmBurstMax consecutive data grants, and a wait counter aborts hung cycles.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AddrWidth     = InstAddrBus,
  parameter int unsigned DataWidth     = InstBus,
  parameter int unsigned DmBurstMax    = 4,
  parameter int unsigned TimeoutCycles = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  // Fetch side
  input  logic                 if_req_i,
  input  logic [AddrWidth-1:0] if_addr_i,
  input  logic                 flush_i,
  output logic [DataWidth-1:0] if_rdata_o,
  output logic                 if_done_o,
  // Load/store side
  input  logic                 dm_req_i,
  input  logic                 dm_we_i,
  input  logic [3:0]           dm_sel_i,
  input  logic [AddrWidth-1:0] dm_addr_i,
  input  logic [DataWidth-1:0] dm_wdata_i,
  output logic [DataWidth-1:0] dm_rdata_o,
  output logic                 dm_done_o,
  // Memory bus
  output logic                 bus_req_o,
  output logic                 bus_we_o,
  output logic [3:0]           bus_sel_o,
  output logic [AddrWidth-1:0] bus_addr_o,
  output logic [DataWidth-1:0] bus_wdata_o,
  input  logic [DataWidth-1:0] bus_rdata_i,
  input  logic                 bus_ack_i,
  // Pipeline status
  output logic                 stall_if_o,
  output logic                 stall_mem_o,
  output logic                 bus_err_o
);

  localparam int unsigned WaitW   = $clog2(TimeoutCycles + 1);
  localparam int unsigned StarveW = $clog2(DmBurstMax + 1);

  arb_state_e state_q, state_d;

  logic                 bus_req_q, bus_req_d;
  logic                 bus_we_q, bus_we_d;
  logic [3:0]           bus_sel_q, bus_sel_d;
  logic [AddrWidth-1:0] bus_addr_q, bus_addr_d;
  logic [DataWidth-1:0] bus_wdata_q, bus_wdata_d;
  logic [DataWidth-1:0] if_rdata_q, if_rdata_d;
  logic [DataWidth-1:0] dm_rdata_q, dm_rdata_d;
  logic                 if_done_q, if_done_d;
  logic                 dm_done_q, dm_done_d;
  logic                 bus_err_q, bus_err_d;
  logic [WaitW-1:0]     wait_cnt_q, wait_cnt_d;
  logic [StarveW-1:0]   starve_cnt_q, starve_cnt_d;
  logic                 drop_q, drop_d;

  logic if_req_eff, dm_req_eff, timeout, starved, drop_now;

  // A requester is ignored in its own done cycle so a held request is not re-granted.
  assign if_req_eff = if_req_i & ~if_done_q & ~flush_i;
  assign dm_req_eff = dm_req_i & ~dm_done_q;
  assign timeout    = (wait_cnt_q == WaitW'(TimeoutCycles - 1));
  assign starved    = (starve_cnt_q == StarveW'(DmBurstMax));
  assign drop_now   = drop_q | flush_i;

  // Next-state: arbitration in idle, completion/timeout handling during transfers.
  always_comb begin
    state_d      = state_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_sel_d    = bus_sel_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    if_done_d    = Disable;
    dm_done_d    = Disable;
    bus_err_d    = Disable;
    wait_cnt_d   = wait_cnt_q;
    starve_cnt_d = starve_cnt_q;
    drop_d       = drop_q;

    unique case (state_q)
      StIdle: begin
        if (dm_req_eff && !(if_req_eff && starved)) begin
          state_d     = StDmXfer;
          bus_req_d   = Enable;
          bus_we_d    = dm_we_i;
          bus_sel_d   = dm_sel_i;
          bus_addr_d  = dm_addr_i;
          bus_wdata_d = dm_wdata_i;
          wait_cnt_d  = '0;
          // Count data grants that made a pending fetch wait.
          if (!if_req_i) begin
            starve_cnt_d = '0;
          end else if (!starved) begin
            starve_cnt_d = starve_cnt_q + StarveW'(1);
          end
        end else if (if_req_eff) begin
          state_d      = StIfXfer;
          bus_req_d    = Enable;
          bus_we_d     = Disable;
          bus_sel_d    = SelWord;
          bus_addr_d   = if_addr_i;
          wait_cnt_d   = '0;
          starve_cnt_d = '0;
        end
      end

      StIfXfer: begin
        if (bus_ack_i || timeout) begin
          state_d   = StIdle;
          bus_req_d = Disable;
          drop_d    = Disable;
          bus_err_d = !bus_ack_i;
          // A flushed fetch still finishes on the bus but is not delivered.
          if (!drop_now) begin
            if_done_d  = Enable;
            if_rdata_d = bus_ack_i ? bus_rdata_i : '0;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
          drop_d     = drop_now;
        end
      end

      StDmXfer: begin
        if (bus_ack_i || timeout) begin
          state_d    = StIdle;
          bus_req_d  = Disable;
          bus_err_d  = !bus_ack_i;
          dm_done_d  = Enable;
          dm_rdata_d = bus_ack_i ? bus_rdata_i : '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset abandons any bus cycle immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (rst_ni == RstActive) begin
      state_q      <= StIdle;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_sel_q    <= '0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      if_done_q    <= 1'b0;
      dm_done_q    <= 1'b0;
      bus_err_q    <= 1'b0;
      wait_cnt_q   <= '0;
      starve_cnt_q <= '0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_sel_q    <= bus_sel_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      if_done_q    <= if_done_d;
      dm_done_q    <= dm_done_d;
      bus_err_q    <= bus_err_d;
      wait_cnt_q   <= wait_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      drop_q       <= drop_d;
    end
  end

  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_sel_o   = bus_sel_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign if_done_o   = if_done_q;
  assign dm_done_o   = dm_done_q;
  assign bus_err_o   = bus_err_q;
  assign stall_if_o  = if_req_i & ~if_done_q;
  assign stall_mem_o = dm_req_i & ~dm_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single transactions plus
// hand-written sequences for priority, timeout, flush and reset.
module tb_mem_arbiter;

  logic        clk, rst_n;
  logic        if_req, flush, if_done;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_done;
  logic [3:0]  dm_sel;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        bus_req, bus_we, bus_ack;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        stall_if, stall_mem, bus_err;

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(
    .AddrWidth    (32),
    .DataWidth    (32),
    .DmBurstMax   (4),
    .TimeoutCycles(15)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .if_req_i   (if_req),
    .if_addr_i  (if_addr),
    .flush_i    (flush),
    .if_rdata_o (if_rdata),
    .if_done_o  (if_done),
    .dm_req_i   (dm_req),
    .dm_we_i    (dm_we),
    .dm_sel_i   (dm_sel),
    .dm_addr_i  (dm_addr),
    .dm_wdata_i (dm_wdata),
    .dm_rdata_o (dm_rdata),
    .dm_done_o  (dm_done),
    .bus_req_o  (bus_req),
    .bus_we_o   (bus_we),
    .bus_sel_o  (bus_sel),
    .bus_addr_o (bus_addr),
    .bus_wdata_o(bus_wdata),
    .bus_rdata_i(bus_rdata),
    .bus_ack_i  (bus_ack),
    .stall_if_o (stall_if),
    .stall_mem_o(stall_mem),
    .bus_err_o  (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        is_dm;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rdata;
    logic [3:0]  exp_sel;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];
  logic prio_got [10];
  logic prio_exp [10];

  function automatic vec_t mk(input logic is_dm, input logic we, input logic [3:0] sel,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int waits, input logic [31:0] rdata,
                              input logic [3:0] exp_sel, input logic [31:0] exp_rdata);
    vec_t v;
    v.is_dm = is_dm; v.we = we; v.sel = sel; v.addr = addr; v.wdata = wdata;
    v.waits = waits; v.rdata = rdata; v.exp_sel = exp_sel; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_grant(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_req && n < 8);
    chk({name, " grant"}, 32'(bus_req), 32'd1);
  endtask

  // One complete transaction from a single requester; starts and ends on a negedge.
  task automatic xfer(input vec_t v, input string name);
    if (v.is_dm) begin
      dm_req = 1'b1; dm_we = v.we; dm_sel = v.sel; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    wait_grant(name);
    if (bus_req) begin
      for (int k = 0; k <= v.waits; k++) begin
        chk({name, " bus_req"}, 32'(bus_req), 32'd1);
        chk({name, " bus_addr"}, bus_addr, v.addr);
        chk({name, " bus_sel"}, 32'(bus_sel), 32'(v.exp_sel));
        chk({name, " bus_we"}, 32'(bus_we), 32'(v.we));
        if (v.is_dm) chk({name, " bus_wdata"}, bus_wdata, v.wdata);
        chk({name, " early done"}, 32'(v.is_dm ? dm_done : if_done), 32'd0);
        chk({name, " stall"}, 32'(v.is_dm ? stall_mem : stall_if), 32'd1);
        if (k == v.waits) begin
          bus_ack = 1'b1; bus_rdata = v.rdata;
        end
        @(negedge clk);
      end
      bus_ack = 1'b0;
      chk({name, " req drop"}, 32'(bus_req), 32'd0);
      chk({name, " done"}, 32'(v.is_dm ? dm_done : if_done), 32'd1);
      chk({name, " rdata"}, v.is_dm ? dm_rdata : if_rdata, v.exp_rdata);
      chk({name, " stall clear"}, 32'(v.is_dm ? stall_mem : stall_if), 32'd0);
      chk({name, " no err"}, 32'(bus_err), 32'd0);
    end
    if_req = 1'b0; dm_req = 1'b0;
    @(negedge clk);
    chk({name, " done pulse"}, 32'(v.is_dm ? dm_done : if_done), 32'd0);
  endtask

  initial begin
    int n;
    int hi;
    int got;

    vecs[0] = mk(0, 0, 4'h0, 32'h0000_0100, 32'h0, 0, 32'h2402_000A, 4'hF, 32'h2402_000A);
    vecs[1] = mk(1, 1, 4'h3, 32'h0000_2000, 32'hDEAD_BEEF, 3, 32'h0000_0000, 4'h3,
                 32'h0000_0000);
    vecs[2] = mk(1, 0, 4'hF, 32'h0000_2004, 32'h0, 1, 32'h1234_5678, 4'hF, 32'h1234_5678);
    vecs[3] = mk(0, 0, 4'h0, 32'h0000_0104, 32'h0, 2, 32'h8C22_0000, 4'hF, 32'h8C22_0000);
    vecs[4] = mk(1, 0, 4'h1, 32'h0000_0003, 32'h0, 0, 32'h0000_00A5, 4'h1, 32'h0000_00A5);
    // Longest wait that still completes before the timeout.
    vecs[5] = mk(0, 0, 4'h0, 32'hFFFF_FFFC, 32'h0, 14, 32'h0000_0013, 4'hF, 32'h0000_0013);
    for (int i = 0; i < 10; i++) prio_exp[i] = (i % 5 != 4);

    rst_n = 1'b0;
    if_req = 0; if_addr = 0; flush = 0; dm_req = 0; dm_we = 0; dm_sel = 0;
    dm_addr = 0; dm_wdata = 0; bus_rdata = 0; bus_ack = 0;
    repeat (3) @(negedge clk);
    chk("reset bus_req", 32'(bus_req), 32'd0);
    chk("reset if_done", 32'(if_done), 32'd0);
    chk("reset dm_done", 32'(dm_done), 32'd0);
    chk("reset bus_err", 32'(bus_err), 32'd0);
    chk("reset if_rdata", if_rdata, 32'd0);
    chk("reset dm_rdata", dm_rdata, 32'd0);
    chk("reset bus_addr", bus_addr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) xfer(vecs[i], $sformatf("vec%0d", i));

    // Timeout on a load with no ack.
    dm_req = 1'b1; dm_we = 1'b0; dm_sel = 4'hF; dm_addr = 32'h0000_4000;
    wait_grant("timeout");
    hi = 0;
    while (bus_req && hi < 40) begin
      hi++;
      @(negedge clk);
    end
    chk("timeout req cycles", hi, 32'd15);
    chk("timeout bus_err", 32'(bus_err), 32'd1);
    chk("timeout dm_done", 32'(dm_done), 32'd1);
    chk("timeout dm_rdata", dm_rdata, 32'd0);
    dm_req = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("late ack bus_err", 32'(bus_err), 32'd0);
    chk("late ack dm_done", 32'(dm_done), 32'd0);
    chk("late ack bus_req", 32'(bus_req), 32'd0);
    chk("late ack dm_rdata", dm_rdata, 32'd0);
    bus_ack = 1'b0;
    @(negedge clk);
    xfer(mk(0, 0, 4'h0, 32'h0000_0108, 32'h0, 0, 32'h0000_0777, 4'hF, 32'h0000_0777),
         "after timeout");

    // Both requesters held; flush masks the fetch in each data-done cycle so the
    // data side can use its full burst before the starvation limit forces a fetch.
    if_addr = 32'h0000_0100; dm_addr = 32'h0000_2000; dm_we = 1'b0; dm_sel = 4'hF;
    if_req = 1'b1; dm_req = 1'b1;
    got = 0; n = 0;
    while (got < 10 && n < 200) begin
      @(negedge clk);
      n++;
      bus_ack = bus_req; flush = dm_done; bus_rdata = 32'h0000_0013;
      if (bus_req) begin
        prio_got[got] = (bus_addr == 32'h0000_2000);
        got++;
      end
    end
    chk("prio grant count", got, 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < got) chk($sformatf("prio grant %0d is data", i), 32'(prio_got[i]),
                       32'(prio_exp[i]));
    end
    @(negedge clk);
    if_req = 1'b0; dm_req = 1'b0; bus_ack = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("prio last if_rdata", if_rdata, 32'h0000_0013);

    // Flush during a fetch: bus cycle completes, result is dropped.
    if_req = 1'b1; if_addr = 32'h0000_0200;
    wait_grant("flush");
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush still on bus", 32'(bus_req), 32'd1);
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("flush req drop", 32'(bus_req), 32'd0);
    chk("flush no if_done", 32'(if_done), 32'd0);
    chk("flush if_rdata kept", if_rdata, 32'h0000_0013);
    chk("flush stall_if", 32'(stall_if), 32'd1);
    wait_grant("flush regrant");
    chk("flush regrant addr", bus_addr, 32'h0000_0200);
    bus_ack = 1'b1; bus_rdata = 32'h0C00_0040;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("flush regrant if_done", 32'(if_done), 32'd1);
    chk("flush regrant if_rdata", if_rdata, 32'h0C00_0040);
    if_req = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of a data transfer.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_5000;
    wait_grant("reset xfer");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset bus_req", 32'(bus_req), 32'd0);
    chk("async reset dm_done", 32'(dm_done), 32'd0);
    chk("async reset bus_err", 32'(bus_err), 32'd0);
    chk("async reset stall_if", 32'(stall_if), 32'd0);
    dm_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post reset bus_req", 32'(bus_req), 32'd0);
    chk("post reset dm_done", 32'(dm_done), 32'd0);
    xfer(mk(1, 0, 4'hF, 32'h0000_5000, 32'h0, 1, 32'h5555_AAAA, 4'hF, 32'h5555_AAAA),
         "post reset load");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
